eth_gt_bringup_sequencer: RTL and testbench

- Free-running controller that sequences bring-up of the shared GTH quad: QPLL0/QPLL1 reset, then per-channel gtwiz_reset_all for NCH 10G Ethernet channels, then the Ethernet core resets.
- Sits beside the shared-logic wrapper. Replaces the combinational powergood-to-qpll-reset tie-off with a timed, retrying sequence.
- Reports link-up and failure, and re-sequences on lock loss or on a user restart.

---
 rtl/eth_gt_pkg.sv | 22 ++
 rtl/eth_gt_bringup_sequencer_sync.sv | 26 ++
 rtl/eth_gt_bringup_sequencer.sv | 152 +++++++++++++++
 tb/tb_eth_gt_bringup_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_gt_pkg.sv
// Shared state encoding and constants for the GT quad bring-up sequencer.
package eth_gt_pkg;

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_WAIT_PG    = 4'd1,
        ST_QPLL_RST   = 4'd2,
        ST_WAIT_LOCK  = 4'd3,
        ST_GT_RST     = 4'd4,
        ST_WAIT_DONE  = 4'd5,
        ST_WAIT_BLOCK = 4'd6,
        ST_RUN        = 4'd7,
        ST_FAIL       = 4'd8
    } gt_state_t;

    localparam logic [3:0] RETRY_SAT = 4'd15;

    function automatic logic [3:0] retry_inc(input logic [3:0] r);
        return (r == RETRY_SAT) ? RETRY_SAT : r + 4'd1;
    endfunction

endpackage

// File: rtl/eth_gt_bringup_sequencer_sync.sv
// Two-flop synchroniser bank for asynchronous status inputs; clears to 0 on reset.
module gt_sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/eth_gt_bringup_sequencer.sv
// Timed, retrying bring-up of a shared GTH quad: QPLL resets, per-channel
// gtwiz_reset_all, then Ethernet core resets; re-sequences on lock loss or restart.
module eth_gt_bringup_sequencer
    import eth_gt_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int QPLL_RST_CYC = 128,
    parameter int GT_RST_CYC   = 64,
    parameter int LOCK_TMO     = 1048576,
    parameter int DONE_TMO     = 1048576,
    parameter int BLK_TMO      = 4194304,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 24
) (
    input  logic           dclk,
    input  logic           sys_reset,
    input  logic           restart_in,
    input  logic [NCH-1:0] gtpowergood_in,
    input  logic           qpll0lock_in,
    input  logic           qpll1lock_in,
    input  logic [NCH-1:0] tx_done_in,
    input  logic [NCH-1:0] rx_done_in,
    input  logic [NCH-1:0] block_lock_in,
    output logic           qpll0reset_out,
    output logic           qpll1reset_out,
    output logic [NCH-1:0] gtwiz_reset_all_out,
    output logic [NCH-1:0] core_reset_out,
    output logic           link_up_out,
    output logic           fail_out,
    output logic [3:0]     state_out,
    output logic [3:0]     retry_cnt_out
);

    localparam int SW = 3 + 4 * NCH;
    localparam logic [CNT_W-1:0] QPLL_LAST = CNT_W'(QPLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(GT_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TMO - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TMO - 1);
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLK_TMO - 1);

    logic [SW-1:0]  raw_bus;
    logic [SW-1:0]  sync_bus;
    logic           restart_sync;
    logic           lock0_sync;
    logic           lock1_sync;
    logic [NCH-1:0] pg_sync;
    logic [NCH-1:0] txd_sync;
    logic [NCH-1:0] rxd_sync;
    logic [NCH-1:0] blk_sync;

    assign raw_bus = {restart_in, qpll0lock_in, qpll1lock_in, gtpowergood_in,
                      tx_done_in, rx_done_in, block_lock_in};

    gt_sync_2ff #(.W(SW)) u_sync (
        .clk (dclk),
        .rst (sys_reset),
        .d   (raw_bus),
        .q   (sync_bus)
    );

    assign {restart_sync, lock0_sync, lock1_sync, pg_sync,
            txd_sync, rxd_sync, blk_sync} = sync_bus;

    gt_state_t      state_reg, state_next;
    logic [CNT_W-1:0] timer_reg;
    logic [3:0]     retry_reg, retry_next;
    logic           restart_q_reg;
    logic           qpll_rst_reg;
    logic [NCH-1:0] gt_rst_reg;
    logic [NCH-1:0] core_rst_reg;
    logic           link_reg;
    logic           fail_reg;

    logic restart_edge, pg_all, lock_ok, done_all, blk_all, tmo;

    assign restart_edge = restart_sync & ~restart_q_reg;
    assign pg_all       = &pg_sync;
    assign lock_ok      = lock0_sync & lock1_sync;
    assign done_all     = (&txd_sync) & (&rxd_sync);
    assign blk_all      = &blk_sync;

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        tmo        = 1'b0;
        // Power loss outranks everything once past WAIT_PG and leaves the retry count alone.
        if (state_reg != ST_RESET && state_reg != ST_WAIT_PG && !pg_all) begin
            state_next = ST_WAIT_PG;
        end else begin
            case (state_reg)
                ST_RESET:      state_next = ST_WAIT_PG;
                ST_WAIT_PG:    if (pg_all) state_next = ST_QPLL_RST;
                ST_QPLL_RST:   if (timer_reg == QPLL_LAST) state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK:  if (lock_ok) state_next = ST_GT_RST;
                               else if (timer_reg == LOCK_LAST) tmo = 1'b1;
                ST_GT_RST:     if (timer_reg == GT_LAST) state_next = ST_WAIT_DONE;
                ST_WAIT_DONE:  if (done_all) state_next = ST_WAIT_BLOCK;
                               else if (timer_reg == DONE_LAST) tmo = 1'b1;
                ST_WAIT_BLOCK: if (blk_all) begin
                                   state_next = ST_RUN;
                                   retry_next = 4'd0;
                               end else if (timer_reg == BLK_LAST) tmo = 1'b1;
                ST_RUN:        if (!lock_ok) state_next = ST_QPLL_RST;
                               else if (!blk_all || restart_edge) state_next = ST_GT_RST;
                ST_FAIL:       if (restart_edge) begin
                                   state_next = ST_QPLL_RST;
                                   retry_next = 4'd0;
                               end
                default:       state_next = ST_RESET;
            endcase
            if (tmo) begin
                retry_next = retry_inc(retry_reg);
                state_next = (int'(retry_next) < MAX_RETRY) ? ST_QPLL_RST : ST_FAIL;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with state_reg.
    always_ff @(posedge dclk or posedge sys_reset) begin
        if (sys_reset) begin
            state_reg     <= ST_RESET;
            timer_reg     <= '0;
            retry_reg     <= 4'd0;
            restart_q_reg <= 1'b0;
            qpll_rst_reg  <= 1'b1;
            gt_rst_reg    <= '1;
            core_rst_reg  <= '1;
            link_reg      <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= (state_next != state_reg) ? '0 : timer_reg + 1'b1;
            retry_reg     <= retry_next;
            restart_q_reg <= restart_sync;
            qpll_rst_reg  <= state_next inside {ST_RESET, ST_WAIT_PG, ST_QPLL_RST, ST_FAIL};
            gt_rst_reg    <= {NCH{!(state_next inside {ST_WAIT_DONE, ST_WAIT_BLOCK, ST_RUN})}};
            core_rst_reg  <= {NCH{!(state_next inside {ST_WAIT_BLOCK, ST_RUN})}};
            link_reg      <= (state_next == ST_RUN);
            fail_reg      <= (state_next == ST_FAIL);
        end
    end

    assign qpll0reset_out      = qpll_rst_reg;
    assign qpll1reset_out      = qpll_rst_reg;
    assign gtwiz_reset_all_out = gt_rst_reg;
    assign core_reset_out      = core_rst_reg;
    assign link_up_out         = link_reg;
    assign fail_out            = fail_reg;
    assign state_out           = state_reg;
    assign retry_cnt_out       = retry_reg;

endmodule

// File: tb/tb_eth_gt_bringup_sequencer.sv
// Bench for the GT bring-up sequencer: table of input steps with expected state,
// retry count and dwell time, plus hand sequences for timer edges and async reset.
module tb_eth_gt_bringup_sequencer;

    localparam int NCH = 2;

    logic           dclk;
    logic           sys_reset;
    logic           restart_in;
    logic [NCH-1:0] gtpowergood_in;
    logic           qpll0lock_in;
    logic           qpll1lock_in;
    logic [NCH-1:0] tx_done_in;
    logic [NCH-1:0] rx_done_in;
    logic [NCH-1:0] block_lock_in;
    logic           qpll0reset_out;
    logic           qpll1reset_out;
    logic [NCH-1:0] gtwiz_reset_all_out;
    logic [NCH-1:0] core_reset_out;
    logic           link_up_out;
    logic           fail_out;
    logic [3:0]     state_out;
    logic [3:0]     retry_cnt_out;

    eth_gt_bringup_sequencer #(
        .NCH(NCH), .QPLL_RST_CYC(4), .GT_RST_CYC(4),
        .LOCK_TMO(16), .DONE_TMO(16), .BLK_TMO(16),
        .MAX_RETRY(2), .CNT_W(24)
    ) dut (
        .dclk                (dclk),
        .sys_reset           (sys_reset),
        .restart_in          (restart_in),
        .gtpowergood_in      (gtpowergood_in),
        .qpll0lock_in        (qpll0lock_in),
        .qpll1lock_in        (qpll1lock_in),
        .tx_done_in          (tx_done_in),
        .rx_done_in          (rx_done_in),
        .block_lock_in       (block_lock_in),
        .qpll0reset_out      (qpll0reset_out),
        .qpll1reset_out      (qpll1reset_out),
        .gtwiz_reset_all_out (gtwiz_reset_all_out),
        .core_reset_out      (core_reset_out),
        .link_up_out         (link_up_out),
        .fail_out            (fail_out),
        .state_out           (state_out),
        .retry_cnt_out       (retry_cnt_out)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    typedef struct {
        string      name;
        logic [1:0] pg;
        logic       l0;
        logic       l1;
        logic [1:0] txd;
        logic [1:0] rxd;
        logic [1:0] blk;
        logic       rs;
        logic [3:0] st;
        logic [3:0] rt;
        int         cyc;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic       qr;
        logic [1:0] gr;
        logic [1:0] cr;
        logic       lu;
        logic       fl;
        logic [3:0] rt;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [1:0] pg, input logic l0,
                                input logic l1, input logic [1:0] txd, input logic [1:0] rxd,
                                input logic [1:0] blk, input logic rs, input logic [3:0] st,
                                input logic [3:0] rt, input int cyc);
        vec_t v;
        v.name = name; v.pg = pg; v.l0 = l0; v.l1 = l1; v.txd = txd; v.rxd = rxd;
        v.blk = blk; v.rs = rs; v.st = st; v.rt = rt; v.cyc = cyc;
        return v;
    endfunction

    // Expected Moore outputs for a state, straight from the decode table.
    function automatic exp_t model(input logic [3:0] st, input logic [3:0] rt);
        exp_t e;
        e.st = st;
        e.rt = rt;
        e.qr = (st == 4'd0 || st == 4'd1 || st == 4'd2 || st == 4'd8);
        e.gr = (st == 4'd5 || st == 4'd6 || st == 4'd7) ? 2'b00 : 2'b11;
        e.cr = (st == 4'd6 || st == 4'd7) ? 2'b00 : 2'b11;
        e.lu = (st == 4'd7);
        e.fl = (st == 4'd8);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic compare_out(input string nm);
        exp_t e;
        e = sb_q.pop_front();
        check({nm, "_state"}, 32'(state_out), 32'(e.st));
        check({nm, "_retry"}, 32'(retry_cnt_out), 32'(e.rt));
        check({nm, "_qpll0rst"}, 32'(qpll0reset_out), 32'(e.qr));
        check({nm, "_qpll1rst"}, 32'(qpll1reset_out), 32'(e.qr));
        check({nm, "_gtrst"}, 32'(gtwiz_reset_all_out), 32'(e.gr));
        check({nm, "_corerst"}, 32'(core_reset_out), 32'(e.cr));
        check({nm, "_linkup"}, 32'(link_up_out), 32'(e.lu));
        check({nm, "_fail"}, 32'(fail_out), 32'(e.fl));
    endtask

    // Drive a step, then count negedges until the expected state shows (bounded).
    task automatic apply_expect(input vec_t v);
        int n;
        gtpowergood_in = v.pg;
        qpll0lock_in   = v.l0;
        qpll1lock_in   = v.l1;
        tx_done_in     = v.txd;
        rx_done_in     = v.rxd;
        block_lock_in  = v.blk;
        restart_in     = v.rs;
        sb_q.push_back(model(v.st, v.rt));
        n = 0;
        while (state_out !== v.st && n < 64) begin
            @(negedge dclk);
            n++;
        end
        $display("step %-16s state=%0d retry=%0d cycles=%0d", v.name, state_out, retry_cnt_out, n);
        compare_out(v.name);
        if (v.cyc >= 0) check({v.name, "_cycles"}, 32'(n), 32'(v.cyc));
    endtask

    initial begin
        sys_reset = 1'b1; restart_in = 1'b0; gtpowergood_in = '0;
        qpll0lock_in = 1'b0; qpll1lock_in = 1'b0;
        tx_done_in = '0; rx_done_in = '0; block_lock_in = '0;

        // Happy path
        vecs.push_back(mk("hp_wait_pg",    2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1));
        vecs.push_back(mk("hp_qpll_rst",   2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2, 0, 3));
        vecs.push_back(mk("hp_wait_lock",  2'b11, 1, 1, 2'b00, 2'b00, 2'b00, 0, 3, 0, 4));
        vecs.push_back(mk("hp_gt_rst",     2'b11, 1, 1, 2'b11, 2'b11, 2'b00, 0, 4, 0, 1));
        vecs.push_back(mk("hp_wait_done",  2'b11, 1, 1, 2'b11, 2'b11, 2'b00, 0, 5, 0, 4));
        vecs.push_back(mk("hp_wait_block", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        vecs.push_back(mk("hp_run",        2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 2));
        // Lock timeout twice into FAIL
        vecs.push_back(mk("lt_lock_loss",  2'b11, 1, 0, 2'b11, 2'b11, 2'b11, 0, 2, 0, 3));
        vecs.push_back(mk("lt_wait_lock1", 2'b11, 1, 0, 2'b11, 2'b11, 2'b11, 0, 3, 0, 4));
        vecs.push_back(mk("lt_timeout1",   2'b11, 1, 0, 2'b11, 2'b11, 2'b11, 0, 2, 1, 16));
        vecs.push_back(mk("lt_wait_lock2", 2'b11, 1, 0, 2'b11, 2'b11, 2'b11, 0, 3, 1, 4));
        vecs.push_back(mk("lt_fail",       2'b11, 1, 0, 2'b11, 2'b11, 2'b11, 0, 8, 2, 16));
        // Recovery from FAIL
        vecs.push_back(mk("rf_restart",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 1, 2, 0, 3));
        vecs.push_back(mk("rf_wait_lock",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 3, 0, 4));
        vecs.push_back(mk("rf_gt_rst",     2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 4, 0, 1));
        vecs.push_back(mk("rf_wait_done",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 5, 0, 4));
        vecs.push_back(mk("rf_wait_block", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        vecs.push_back(mk("rf_run",        2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));
        // RUN disturbances
        vecs.push_back(mk("rd_blk_loss",   2'b11, 1, 1, 2'b11, 2'b11, 2'b01, 0, 4, 0, 3));
        vecs.push_back(mk("rd_gt_hold",    2'b11, 1, 1, 2'b11, 2'b11, 2'b01, 0, 5, 0, 4));
        vecs.push_back(mk("rd_blk_back",   2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        vecs.push_back(mk("rd_run1",       2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 2));
        vecs.push_back(mk("rd_q0_loss",    2'b11, 0, 1, 2'b11, 2'b11, 2'b11, 0, 2, 0, 3));
        vecs.push_back(mk("rd_q0_back",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 3, 0, 4));
        vecs.push_back(mk("rd_gt_rst2",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 4, 0, 1));
        vecs.push_back(mk("rd_wait_done2", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 5, 0, 4));
        vecs.push_back(mk("rd_wait_blk2",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        vecs.push_back(mk("rd_run2",       2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));
        vecs.push_back(mk("rd_restart",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 1, 4, 0, 3));
        vecs.push_back(mk("rd_wait_done3", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 5, 0, 4));
        vecs.push_back(mk("rd_wait_blk3",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        vecs.push_back(mk("rd_run3",       2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));
        // Powergood beats lock loss
        vecs.push_back(mk("pr_pg_lock",    2'b10, 0, 1, 2'b11, 2'b11, 2'b11, 0, 1, 0, 3));
        vecs.push_back(mk("pr_pg_back",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 2, 0, 3));
        vecs.push_back(mk("pr_wait_lock",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 3, 0, 4));
        vecs.push_back(mk("pr_gt_rst",     2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 4, 0, 1));
        vecs.push_back(mk("pr_wait_done",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 5, 0, 4));
        vecs.push_back(mk("pr_wait_block", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        vecs.push_back(mk("pr_run",        2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));

        repeat (3) @(negedge dclk);
        sb_q.push_back(model(4'd0, 4'd0));
        compare_out("reset_state");
        sys_reset = 1'b0;

        foreach (vecs[i]) apply_expect(vecs[i]);

        // Last done bit lands on the timer==15 cycle: exit wins over timeout.
        apply_expect(mk("dt_restart",    2'b11, 1, 1, 2'b11, 2'b01, 2'b11, 1, 4, 0, 3));
        apply_expect(mk("dt_wait_done",  2'b11, 1, 1, 2'b11, 2'b01, 2'b11, 0, 5, 0, 4));
        repeat (13) @(negedge dclk);
        apply_expect(mk("dt_done_at_15", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 3));
        apply_expect(mk("dt_run",        2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));

        // One cycle later the timeout fires instead.
        apply_expect(mk("dt2_restart",   2'b11, 1, 1, 2'b11, 2'b01, 2'b11, 1, 4, 0, 3));
        apply_expect(mk("dt2_wait_done", 2'b11, 1, 1, 2'b11, 2'b01, 2'b11, 0, 5, 0, 4));
        repeat (14) @(negedge dclk);
        apply_expect(mk("dt2_late",      2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 2, 1, 2));
        apply_expect(mk("dt2_wait_lock", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 3, 1, 4));
        apply_expect(mk("dt2_gt_rst",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 4, 1, 1));
        apply_expect(mk("dt2_wait_done2",2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 5, 1, 4));
        apply_expect(mk("dt2_wait_blk",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 1, 1));
        apply_expect(mk("dt2_run",       2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));

        // Mid-sequence asynchronous reset from WAIT_DONE.
        apply_expect(mk("mr_restart",    2'b11, 1, 1, 2'b11, 2'b01, 2'b11, 1, 4, 0, 3));
        apply_expect(mk("mr_wait_done",  2'b11, 1, 1, 2'b11, 2'b01, 2'b11, 0, 5, 0, 4));
        sys_reset = 1'b1;
        #1;
        sb_q.push_back(model(4'd0, 4'd0));
        compare_out("mr_async");
        @(negedge dclk);
        sb_q.push_back(model(4'd0, 4'd0));
        compare_out("mr_held");
        sys_reset = 1'b0;
        apply_expect(mk("mr_wait_pg",    2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 1, 0, 1));
        apply_expect(mk("mr_qpll_rst",   2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 2, 0, 2));
        apply_expect(mk("mr_wait_lock",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 3, 0, 4));
        apply_expect(mk("mr_gt_rst",     2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 4, 0, 1));
        apply_expect(mk("mr_wait_done",  2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 5, 0, 4));
        apply_expect(mk("mr_wait_block", 2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 6, 0, 1));
        apply_expect(mk("mr_run",        2'b11, 1, 1, 2'b11, 2'b11, 2'b11, 0, 7, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
